id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage for the non-forwarding RV32I pipeline. Sits directly downstream of the instruction decoder.
- Registers the decoder control fields, immediate, PC and register-file read data into the EX stage.
- Contains the RAW hazard scoreboard. It stalls the ID stage, and inserts bubbles, until a producer's result is architecturally visible in the regfile.
- Honours branch/jump flushes resolved in EX. Keeps a saturating stall-cycle performance counter.

Parameters:
- HAZ_DEPTH, 3, number of in-flight stages (EX, MEM, WB, ...) whose destination blocks issue. Use 3 when the regfile has no write-through; use 2 when it has write-through. Legal range 1..4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_pc  in  32  PC of the ID instruction
- rs1_addr, rs2_addr, rd_addr  in  5 each  from decoder; an unused source reads as 0
- rd_wren, branch, jump, op_a_sel, op_b_sel, mem_wren, is_load  in  1 each  from decoder
- alu_op  in  4  from decoder
- br_op  in  3  from decoder
- ld_op  in  4  from decoder
- imm  in  32  from decoder
- rs1_data, rs2_data  in  32 each  regfile read data
- flush  in  1  taken branch/jump resolved in EX this cycle
- id_stall  out  1  hold PC and IF/ID register this cycle
- ex_valid  out  1  EX register holds a real instruction
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  32 each  registered copies
- ex_rd_addr  out  5
- ex_rd_wren, ex_branch, ex_jump, ex_op_a_sel, ex_op_b_sel, ex_mem_wren, ex_is_load  out  1 each
- ex_alu_op  out  4
- ex_br_op  out  3
- ex_ld_op  out  4
- perf_stall_cnt  out  32  cycles with id_stall=1

Behaviour:
Reset:
- rst asserted: all ex_* outputs = 0, ex_valid = 0, scoreboard all invalid, perf_stall_cnt = 0.
- Takes effect immediately, independent of clk, including mid-stall.

Scoreboard:
- HAZ_DEPTH entries of {v, rd}. Entry 0 corresponds to the instruction in EX.
- Every clock: entry[k] <= entry[k-1] for k≥1.
- entry[0] <= {1, rd_addr} on an issue with rd_wren=1 and rd_addr≠0; otherwise entry[0] <= {0, 0}.

Hazard (combinational):
- hazard = id_valid AND there exists k with entry[k].v AND entry[k].rd equal to a nonzero rs1_addr or a nonzero rs2_addr.
- x0 never creates a hazard.

Stall:
- id_stall = hazard AND NOT flush. Combinational; no latency.

Issue (next clock edge):
- issue = id_valid AND NOT hazard AND NOT flush.
- On issue: every ex_* loads its ID counterpart and ex_valid = 1. Latency is 1 cycle.
- Otherwise a bubble is inserted: ex_valid = 0 and every ex_* = 0, so control fields are all inactive.

Flush:
- The ID instruction is discarded, a bubble is inserted, and entry[0] becomes invalid.
- Older entries still shift, because those instructions precede the branch and complete.
- flush overrides hazard.

Stall duration:
- A consumer immediately after its producer stalls exactly HAZ_DEPTH cycles.
- A consumer separated by n independent instructions stalls max(0, HAZ_DEPTH−n) cycles.

perf_stall_cnt:
- Increments by 1 on each clock with id_stall=1.
- Saturates at 32'hFFFF_FFFF with no wrap.

Other rules:
- A store's rs2 and a branch's rs1/rs2 are checked identically to ALU sources.
- JAL with rs1_addr=0 is never stalled.
- Simultaneous flush and rst: rst wins.

Test Plan:
1. Reset during a stall: rst=1 while ex_valid=1, ex_rd_wren=1 → all outputs 0 before the next edge. After release, a dependent instruction issues with no stall, since the scoreboard is clear.
2. HAZ_DEPTH=3, addi x5,x0,7 then add x6,x5,x1 back-to-back → id_stall=1 for exactly 3 cycles. Three bubbles appear (ex_valid=0). The add then issues with ex_rd_addr=6. perf_stall_cnt=3.
3. HAZ_DEPTH=2, same sequence → exactly 2 stall cycles. With one independent instruction in between → 1 stall cycle.
4. addi x0,x0,1 then add x6,x0,x0 → no stall. ex_valid=1 on consecutive cycles; entry[0] invalid.
5. lw x7,0(x2) followed by sw x7,4(x3) with flush=1 on the second stall cycle → id_stall drops to 0 that cycle and ex_valid=0 next cycle. The lw entry keeps shifting, so a later reader of x7 stalls only for the remaining depth.
6. Counter saturation: preload via a long stall (or force) to 32'hFFFF_FFFE, then stall 3 cycles → perf_stall_cnt holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoder fields and regfile data into the stage, the registered EX bundle,
// the stall back to ID and the stall counter out of it.
interface id_ex_stage_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic        branch;
    logic        jump;
    logic        op_a_sel;
    logic        op_b_sel;
    logic        mem_wren;
    logic        is_load;
    logic [3:0]  alu_op;
    logic [2:0]  br_op;
    logic [3:0]  ld_op;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;

    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_wren;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_op_a_sel;
    logic        ex_op_b_sel;
    logic        ex_mem_wren;
    logic        ex_is_load;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_br_op;
    logic [3:0]  ex_ld_op;
    logic [31:0] perf_stall_cnt;

    modport master (
        output id_valid, id_pc, rs1_addr, rs2_addr, rd_addr, rd_wren, branch, jump,
               op_a_sel, op_b_sel, mem_wren, is_load, alu_op, br_op, ld_op, imm,
               rs1_data, rs2_data, flush,
        input  id_stall, ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rd_addr,
               ex_rd_wren, ex_branch, ex_jump, ex_op_a_sel, ex_op_b_sel, ex_mem_wren,
               ex_is_load, ex_alu_op, ex_br_op, ex_ld_op, perf_stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, rs1_addr, rs2_addr, rd_addr, rd_wren, branch, jump,
               op_a_sel, op_b_sel, mem_wren, is_load, alu_op, br_op, ld_op, imm,
               rs1_data, rs2_data, flush,
        output id_stall, ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rd_addr,
               ex_rd_wren, ex_branch, ex_jump, ex_op_a_sel, ex_op_b_sel, ex_mem_wren,
               ex_is_load, ex_alu_op, ex_br_op, ex_ld_op, perf_stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the non-forwarding RV32I pipeline, with the RAW hazard
// scoreboard that stalls ID until a producer's result is readable from the regfile.
module id_ex_stage #(
    parameter int unsigned HAZ_DEPTH = 3  // 3 without regfile write-through, 2 with it
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        logic        rd_wren;
        logic        branch;
        logic        jump;
        logic        op_a_sel;
        logic        op_b_sel;
        logic        mem_wren;
        logic        is_load;
        logic [3:0]  alu_op;
        logic [2:0]  br_op;
        logic [3:0]  ld_op;
    } ex_t;

    // Entry 0 tracks the instruction currently in EX; higher entries are older.
    sb_entry_t [HAZ_DEPTH-1:0] sb_q, sb_d;
    ex_t                       ex_q, ex_d;
    logic                      ex_valid_q, ex_valid_d;
    logic [31:0]               perf_stall_cnt_q, perf_stall_cnt_d;
    logic                      hazard;
    logic                      id_stall;
    logic                      issue;

    // RAW detect against every in-flight destination; x0 is never a dependency.
    always_comb begin
        logic match;
        match = 1'b0;
        for (int unsigned k = 0; k < HAZ_DEPTH; k++) begin
            if (sb_q[k].v) begin
                if ((bus.rs1_addr != 5'd0) && (sb_q[k].rd == bus.rs1_addr)) match = 1'b1;
                if ((bus.rs2_addr != 5'd0) && (sb_q[k].rd == bus.rs2_addr)) match = 1'b1;
            end
        end
        hazard   = bus.id_valid && match;
        id_stall = hazard && !bus.flush;
        issue    = bus.id_valid && !hazard && !bus.flush;
    end

    // Next EX bundle, scoreboard shift and saturating stall counter.
    always_comb begin
        ex_d       = '0;
        ex_valid_d = 1'b0;
        sb_d       = '0;
        if (issue) begin
            ex_valid_d    = 1'b1;
            ex_d.pc       = bus.id_pc;
            ex_d.imm      = bus.imm;
            ex_d.rs1_data = bus.rs1_data;
            ex_d.rs2_data = bus.rs2_data;
            ex_d.rd_addr  = bus.rd_addr;
            ex_d.rd_wren  = bus.rd_wren;
            ex_d.branch   = bus.branch;
            ex_d.jump     = bus.jump;
            ex_d.op_a_sel = bus.op_a_sel;
            ex_d.op_b_sel = bus.op_b_sel;
            ex_d.mem_wren = bus.mem_wren;
            ex_d.is_load  = bus.is_load;
            ex_d.alu_op   = bus.alu_op;
            ex_d.br_op    = bus.br_op;
            ex_d.ld_op    = bus.ld_op;
        end
        // Older entries keep moving even on flush: they precede the branch and complete.
        for (int unsigned k = 1; k < HAZ_DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        if (issue && bus.rd_wren && (bus.rd_addr != 5'd0)) begin
            sb_d[0].v  = 1'b1;
            sb_d[0].rd = bus.rd_addr;
        end
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (id_stall && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
    end

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q             <= '0;
            ex_q             <= '0;
            ex_valid_q       <= 1'b0;
            perf_stall_cnt_q <= '0;
        end else begin
            sb_q             <= sb_d;
            ex_q             <= ex_d;
            ex_valid_q       <= ex_valid_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign bus.id_stall       = id_stall;
    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_imm         = ex_q.imm;
    assign bus.ex_rs1_data    = ex_q.rs1_data;
    assign bus.ex_rs2_data    = ex_q.rs2_data;
    assign bus.ex_rd_addr     = ex_q.rd_addr;
    assign bus.ex_rd_wren     = ex_q.rd_wren;
    assign bus.ex_branch      = ex_q.branch;
    assign bus.ex_jump        = ex_q.jump;
    assign bus.ex_op_a_sel    = ex_q.op_a_sel;
    assign bus.ex_op_b_sel    = ex_q.op_b_sel;
    assign bus.ex_mem_wren    = ex_q.mem_wren;
    assign bus.ex_is_load     = ex_q.is_load;
    assign bus.ex_alu_op      = ex_q.alu_op;
    assign bus.ex_br_op       = ex_q.br_op;
    assign bus.ex_ld_op       = ex_q.ld_op;
    assign bus.perf_stall_cnt = perf_stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: one instance at HAZ_DEPTH=3 and one at HAZ_DEPTH=2, driven with
// identical inputs and checked against a per-register "last written" cycle model.
module tb_id_ex_stage;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wren;
        logic        branch;
        logic        jump;
        logic        op_a_sel;
        logic        op_b_sel;
        logic        mem_wren;
        logic        is_load;
        logic [3:0]  alu_op;
        logic [2:0]  br_op;
        logic [3:0]  ld_op;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } instr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        rd_wren;
        logic        branch;
        logic        jump;
        logic        op_a_sel;
        logic        op_b_sel;
        logic        mem_wren;
        logic        is_load;
        logic [3:0]  alu_op;
        logic [2:0]  br_op;
        logic [3:0]  ld_op;
    } ex_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if if3 ();
    id_ex_stage_if if2 ();

    id_ex_stage #(.HAZ_DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    id_ex_stage #(.HAZ_DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int          n_vec = 0;
    int          n_err = 0;
    longint      cyc = 0;
    longint      last_wr [2][32];  // cycle at which each register's producer left ID
    int          depth   [2] = '{3, 2};
    ex_t         exp_ex  [2];
    logic        exp_valid [2];
    logic [31:0] exp_perf  [2];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 32; r++) last_wr[m][r] = -1000;
            exp_ex[m]    = '0;
            exp_valid[m] = 1'b0;
            exp_perf[m]  = '0;
        end
    endtask

    // A source is busy while its producer is still within the last depth cycles of issue.
    function automatic logic model_hazard(input int m, input instr_t in);
        logic b1, b2;
        b1 = (in.rs1 != 5'd0) && ((cyc - last_wr[m][in.rs1]) <= longint'(depth[m]));
        b2 = (in.rs2 != 5'd0) && ((cyc - last_wr[m][in.rs2]) <= longint'(depth[m]));
        return in.valid && (b1 || b2);
    endfunction

    function automatic ex_t to_ex(input instr_t in);
        ex_t e;
        e.pc = in.pc; e.imm = in.imm; e.rs1_data = in.rs1_data; e.rs2_data = in.rs2_data;
        e.rd = in.rd; e.rd_wren = in.rd_wren; e.branch = in.branch; e.jump = in.jump;
        e.op_a_sel = in.op_a_sel; e.op_b_sel = in.op_b_sel; e.mem_wren = in.mem_wren;
        e.is_load = in.is_load; e.alu_op = in.alu_op; e.br_op = in.br_op; e.ld_op = in.ld_op;
        return e;
    endfunction

    function automatic ex_t obs_ex(input int m);
        ex_t e;
        if (m == 0) begin
            e = '{if3.ex_pc, if3.ex_imm, if3.ex_rs1_data, if3.ex_rs2_data, if3.ex_rd_addr,
                  if3.ex_rd_wren, if3.ex_branch, if3.ex_jump, if3.ex_op_a_sel,
                  if3.ex_op_b_sel, if3.ex_mem_wren, if3.ex_is_load, if3.ex_alu_op,
                  if3.ex_br_op, if3.ex_ld_op};
        end else begin
            e = '{if2.ex_pc, if2.ex_imm, if2.ex_rs1_data, if2.ex_rs2_data, if2.ex_rd_addr,
                  if2.ex_rd_wren, if2.ex_branch, if2.ex_jump, if2.ex_op_a_sel,
                  if2.ex_op_b_sel, if2.ex_mem_wren, if2.ex_is_load, if2.ex_alu_op,
                  if2.ex_br_op, if2.ex_ld_op};
        end
        return e;
    endfunction

    function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic wren,
                                  input logic load, input logic store);
        instr_t i;
        i.valid = 1'b1; i.pc = $urandom; i.imm = $urandom;
        i.rs1_data = $urandom; i.rs2_data = $urandom;
        i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.rd_wren = wren;
        i.is_load = load; i.mem_wren = store; i.branch = 1'b0; i.jump = 1'b0;
        i.op_a_sel = 1'($urandom); i.op_b_sel = 1'($urandom);
        i.alu_op = 4'($urandom); i.br_op = 3'($urandom); i.ld_op = 4'($urandom);
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), 1'($urandom));
        i.valid  = ($urandom_range(0, 99) < 85);
        i.branch = 1'($urandom);
        i.jump   = 1'($urandom);
        return i;
    endfunction

    task automatic drive(input instr_t in, input logic fl);
        if3.id_valid = in.valid;    if2.id_valid = in.valid;
        if3.id_pc = in.pc;          if2.id_pc = in.pc;
        if3.rs1_addr = in.rs1;      if2.rs1_addr = in.rs1;
        if3.rs2_addr = in.rs2;      if2.rs2_addr = in.rs2;
        if3.rd_addr = in.rd;        if2.rd_addr = in.rd;
        if3.rd_wren = in.rd_wren;   if2.rd_wren = in.rd_wren;
        if3.branch = in.branch;     if2.branch = in.branch;
        if3.jump = in.jump;         if2.jump = in.jump;
        if3.op_a_sel = in.op_a_sel; if2.op_a_sel = in.op_a_sel;
        if3.op_b_sel = in.op_b_sel; if2.op_b_sel = in.op_b_sel;
        if3.mem_wren = in.mem_wren; if2.mem_wren = in.mem_wren;
        if3.is_load = in.is_load;   if2.is_load = in.is_load;
        if3.alu_op = in.alu_op;     if2.alu_op = in.alu_op;
        if3.br_op = in.br_op;       if2.br_op = in.br_op;
        if3.ld_op = in.ld_op;       if2.ld_op = in.ld_op;
        if3.imm = in.imm;           if2.imm = in.imm;
        if3.rs1_data = in.rs1_data; if2.rs1_data = in.rs1_data;
        if3.rs2_data = in.rs2_data; if2.rs2_data = in.rs2_data;
        if3.flush = fl;             if2.flush = fl;
    endtask

    task automatic check_outputs();
        chk("ex_bundle_d3", 160'(obs_ex(0)), 160'(exp_ex[0]));
        chk("ex_valid_d3", 160'(if3.ex_valid), 160'(exp_valid[0]));
        chk("perf_d3", 160'(if3.perf_stall_cnt), 160'(exp_perf[0]));
        chk("ex_bundle_d2", 160'(obs_ex(1)), 160'(exp_ex[1]));
        chk("ex_valid_d2", 160'(if2.ex_valid), 160'(exp_valid[1]));
        chk("perf_d2", 160'(if2.perf_stall_cnt), 160'(exp_perf[1]));
    endtask

    // One ID cycle: apply at negedge, check the stall, advance the model, check after the edge.
    task automatic step(input instr_t in, input logic fl, output logic st3, output logic st2);
        logic h, st;
        @(negedge clk);
        drive(in, fl);
        #1;
        st3 = if3.id_stall;
        st2 = if2.id_stall;
        for (int m = 0; m < 2; m++) begin
            h  = model_hazard(m, in);
            st = h && !fl;
            if (m == 0) chk("id_stall_d3", 160'(st3), 160'(st));
            else        chk("id_stall_d2", 160'(st2), 160'(st));
            if (in.valid && !h && !fl) begin
                exp_ex[m]    = to_ex(in);
                exp_valid[m] = 1'b1;
                if (in.rd_wren && (in.rd != 5'd0)) last_wr[m][in.rd] = cyc;
            end else begin
                exp_ex[m]    = '0;
                exp_valid[m] = 1'b0;
            end
            if (st && (exp_perf[m] != 32'hFFFF_FFFF)) exp_perf[m] = exp_perf[m] + 32'd1;
        end
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        logic s3, s2;
        for (int i = 0; i < n; i++) step('0, 1'b0, s3, s2);
    endtask

    // Hold an instruction in ID until the depth-3 instance lets it go; bounded.
    task automatic hold_until_issue(input instr_t in, output int c3, output int c2);
        logic s3, s2;
        c3 = 0;
        c2 = 0;
        for (int i = 0; i < 8; i++) begin
            step(in, 1'b0, s3, s2);
            c3 += int'(s3);
            c2 += int'(s2);
            if (!s3) break;
        end
    endtask

    initial begin
        instr_t cur;
        logic   s3, s2;
        int     c3, c2;

        // Reset state.
        rst = 1'b1;
        drive('0, 1'b0);
        model_reset();
        #1;
        check_outputs();
        chk("rst_stall_d3", 160'(if3.id_stall), 160'(0));
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back producer/consumer: addi x5,x0,7 ; add x6,x5,x1.
        step(mk(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, s3, s2);
        hold_until_issue(mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0), c3, c2);
        chk("b2b_stalls_d3", 160'(c3), 160'(3));
        chk("b2b_stalls_d2", 160'(c2), 160'(2));
        chk("b2b_rd_d3", 160'(if3.ex_rd_addr), 160'(6));
        chk("b2b_perf_d3", 160'(if3.perf_stall_cnt), 160'(3));

        // One independent instruction in between.
        idle(4);
        step(mk(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, s3, s2);
        step(mk(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, s3, s2);
        hold_until_issue(mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0), c3, c2);
        chk("gap1_stalls_d3", 160'(c3), 160'(2));
        chk("gap1_stalls_d2", 160'(c2), 160'(1));

        // Writes to x0 never block: addi x0,x0,1 ; add x6,x0,x0.
        idle(4);
        step(mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, s3, s2);
        hold_until_issue(mk(5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), c3, c2);
        chk("x0_stalls_d3", 160'(c3), 160'(0));
        chk("x0_valid_d3", 160'(if3.ex_valid), 160'(1));

        // lw x7 ; sw x7 flushed on its second stall cycle ; later reader of x7.
        idle(4);
        cur = mk(5'd7, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
        step(cur, 1'b0, s3, s2);
        cur = mk(5'd0, 5'd3, 5'd7, 1'b0, 1'b0, 1'b1);
        step(cur, 1'b0, s3, s2);
        step(cur, 1'b1, s3, s2);
        chk("flush_stall_d3", 160'(s3), 160'(0));
        chk("flush_bubble_d3", 160'(if3.ex_valid), 160'(0));
        hold_until_issue(mk(5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0), c3, c2);
        chk("post_flush_stalls_d3", 160'(c3), 160'(1));
        chk("post_flush_stalls_d2", 160'(c2), 160'(0));

        // Asynchronous reset while a consumer is stalled behind a producer in EX.
        idle(4);
        step(mk(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, s3, s2);
        cur = mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(cur, 1'b0);
        #1;
        chk("pre_rst_stall_d3", 160'(if3.id_stall), 160'(1));
        chk("pre_rst_wren_d3", 160'(if3.ex_rd_wren), 160'(1));
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rst_clears_sb_d3", 160'(if3.id_stall), 160'(0));
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        hold_until_issue(cur, c3, c2);
        chk("post_rst_stalls_d3", 160'(c3), 160'(0));

        // Randomized traffic; a stalled instruction is held in ID as the real pipeline would.
        s3 = 1'b0;
        cur = rand_instr();
        for (int i = 0; i < 400; i++) begin
            if (!s3) cur = rand_instr();
            step(cur, ($urandom_range(0, 9) == 0), s3, s2);
        end

        // Counter saturation from a preloaded value.
        idle(4);
        force dut3.perf_stall_cnt_q = 32'hFFFF_FFFE;
        force dut2.perf_stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut3.perf_stall_cnt_q;
        release dut2.perf_stall_cnt_q;
        exp_perf[0] = 32'hFFFF_FFFE;
        exp_perf[1] = 32'hFFFF_FFFE;
        step(mk(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), 1'b0, s3, s2);
        hold_until_issue(mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0), c3, c2);
        chk("sat_perf_d3", 160'(if3.perf_stall_cnt), 160'(32'hFFFF_FFFF));
        chk("sat_perf_d2", 160'(if2.perf_stall_cnt), 160'(32'hFFFF_FFFF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
